// File: rtl/semiring_pkg.sv
`default_nettype none
// ============================================================================
// Module   : semiring_pkg
// Purpose  : Shared constants for the semiring dot-product sequencer: function
//            encodings, operand lane indices/packing and the min identity.
// Revision : 1.0 - initial release
// ============================================================================
package semiring_pkg;

  // Function select driven to the reduction unit.
  typedef enum logic [0:0] {
    FUNC_MINPLUS  = 1'b0,
    FUNC_MINTIMES = 1'b1
  } func_e;

  // Lane packing, lane 0 in the LSBs: {d2,d1,c2,c1,b2,b1,a2,a1}.
  localparam int unsigned A1 = 0;
  localparam int unsigned A2 = 1;
  localparam int unsigned B1 = 2;
  localparam int unsigned B2 = 3;
  localparam int unsigned C1 = 4;
  localparam int unsigned C2 = 5;
  localparam int unsigned D1 = 6;
  localparam int unsigned D2 = 7;
  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned NUM_PAIRS = 4;

  // Identity of unsigned min for a W-bit datapath (all ones), W <= 64.
  function automatic logic [63:0] ident_of(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage : semiring_pkg
`default_nettype wire

// File: rtl/sdseq_keep_mux.sv
`default_nettype none
// ============================================================================
// Module   : sdseq_keep_mux
// Purpose  : Replaces every disabled operand pair by pair a. Since min is
//            idempotent the reduced result is unaffected by the duplicates.
// Revision : 1.0 - initial release
// ============================================================================
module sdseq_keep_mux
  import semiring_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [8*W-1:0] pairs_i,
  input  logic [3:0]     keep_i,
  output logic [8*W-1:0] pairs_o
);

  logic [2*W-1:0] w_pair_a;
  logic [3:0]     w_keep_eff;

  // Pair a is always kept, even when its keep bit is (illegally) low.
  assign w_pair_a   = pairs_i[2*W*A1 +: 2*W];
  assign w_keep_eff = keep_i | 4'b0001;

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    assign pairs_o[2*W*p +: 2*W] = w_keep_eff[p] ? pairs_i[2*W*p +: 2*W] : w_pair_a;
  end

endmodule : sdseq_keep_mux
`default_nettype wire

// File: rtl/semiring_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : semiring_dot_sequencer
// Purpose  : Streams 4-pair operand beats onto an external combinational
//            min-reduction unit, accumulates the running minimum across the
//            beats of a vector and presents the scalar in a valid/ready slot.
// Revision : 1.0 - initial release
// ============================================================================
module semiring_dot_sequencer
  import semiring_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [8*W-1:0]   in_pairs_i,
  input  logic [3:0]       in_keep_i,
  input  logic             in_last_i,
  input  logic             in_func_i,
  output logic [8*W-1:0]   red_ops_o,
  output logic [W-1:0]     red_e_o,
  output logic             red_func_o,
  input  logic [W-1:0]     red_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [W-1:0]     res_data_o,
  output logic [CNT_W-1:0] res_beats_o
);

  localparam logic [63:0]  IDENT_WIDE = ident_of(W);
  localparam logic [W-1:0] IDENT      = IDENT_WIDE[W-1:0];

  logic [8*W-1:0]   op_q, op_d;
  logic             op_last_q, op_last_d;
  logic             op_v_q, op_v_d;
  func_e            func_q, func_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic [CNT_W-1:0] res_beats_q, res_beats_d;

  logic [8*W-1:0]   w_kept;
  logic             w_adv;
  logic             w_accept;
  logic             w_in_first;
  logic             w_step;
  logic [CNT_W-1:0] w_cnt_inc;

  sdseq_keep_mux #(.W(W)) u_keep_mux (
    .pairs_i (in_pairs_i),
    .keep_i  (in_keep_i),
    .pairs_o (w_kept)
  );

  // Handshake, beat-position and next-state logic for both pipeline stages.
  always_comb begin
    op_d        = op_q;
    op_last_d   = op_last_q;
    op_v_d      = op_v_q;
    func_d      = func_q;
    acc_d       = acc_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_beats_d = res_beats_q;

    // Only a pending last beat facing a full, unconsumed slot stalls the pipe.
    w_adv      = !op_v_q || !op_last_q || !res_valid_q || res_ready_i;
    in_ready_o = rst_n && w_adv;
    w_accept   = in_valid_i && in_ready_o;
    w_step     = op_v_q && w_adv;
    w_cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    // first_q describes the beat in the operand stage; an incoming beat
    // starts a vector only if the staged beat closes one (or the stage is
    // empty and no partial vector is accumulated).
    w_in_first = op_v_q ? op_last_q : first_q;

    if (w_adv) begin
      if (w_accept) begin
        op_d      = w_kept;
        op_last_d = in_last_i;
        op_v_d    = 1'b1;
        if (w_in_first) func_d = func_e'(in_func_i);
      end else begin
        op_v_d = 1'b0;
      end
    end

    if (res_valid_q && res_ready_i) res_valid_d = 1'b0;

    if (w_step) begin
      if (!op_last_q) begin
        acc_d   = red_out_i;
        first_d = 1'b0;
        cnt_d   = w_cnt_inc;
      end else begin
        res_data_d  = red_out_i;
        res_beats_d = w_cnt_inc;
        res_valid_d = 1'b1;
        acc_d       = IDENT;
        first_d     = 1'b1;
        cnt_d       = '0;
      end
    end
  end

  // State registers; reset discards any partial vector and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      op_last_q   <= 1'b0;
      op_v_q      <= 1'b0;
      func_q      <= FUNC_MINPLUS;
      acc_q       <= IDENT;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_beats_q <= '0;
    end else begin
      op_q        <= op_d;
      op_last_q   <= op_last_d;
      op_v_q      <= op_v_d;
      func_q      <= func_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign red_ops_o   = op_q;
  assign red_func_o  = func_q;
  assign red_e_o     = first_q ? IDENT : acc_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_beats_o = res_beats_q;

endmodule : semiring_dot_sequencer
`default_nettype wire

// File: tb/tb_semiring_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_semiring_dot_sequencer
// Purpose  : Directed self-checking bench with a result scoreboard and a
//            behavioural model of the external min-reduction unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_semiring_dot_sequencer;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8*W-1:0]   in_pairs = '0;
  logic [3:0]       in_keep = 4'hF;
  logic             in_last = 1'b0;
  logic             in_func = 1'b0;
  logic [8*W-1:0]   red_ops;
  logic [W-1:0]     red_e;
  logic             red_func;
  logic [W-1:0]     red_out;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [W-1:0]     res_data;
  logic [CNT_W-1:0] res_beats;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] sb_q[$];

  semiring_dot_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pairs_i  (in_pairs),
    .in_keep_i   (in_keep),
    .in_last_i   (in_last),
    .in_func_i   (in_func),
    .red_ops_o   (red_ops),
    .red_e_o     (red_e),
    .red_func_o  (red_func),
    .red_out_i   (red_out),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_beats_o (res_beats)
  );

  always #5 clk = ~clk;

  // Cycle counter for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // External reduction unit: min(e, f(a1,a2), f(b1,b2), f(c1,c2), f(d1,d2)).
  function automatic logic [W-1:0] red_model(input logic [8*W-1:0] ops,
                                             input logic [W-1:0] e, input logic f);
    logic [W-1:0] m, x, y, v;
    m = e;
    for (int i = 0; i < 4; i++) begin
      x = ops[2*i*W +: W];
      y = ops[(2*i+1)*W +: W];
      v = f ? W'(x * y) : W'(x + y);
      if (v < m) m = v;
    end
    return m;
  endfunction

  always_comb red_out = red_model(red_ops, red_e, red_func);

  function automatic logic [8*W-1:0] pk(input logic [W-1:0] a1, a2, b1, b2,
                                        c1, c2, d1, d2);
    return {d2, d1, c2, c1, b2, b1, a2, a1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and return 1ns after the edge that accepts it.
  task automatic send(input logic [8*W-1:0] p, input logic [3:0] k,
                      input logic l, input logic f);
    int n;
    in_valid = 1'b1; in_pairs = p; in_keep = k; in_last = l; in_func = f;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_res(input logic [W-1:0] d, input logic [CNT_W-1:0] b);
    sb_q.push_back({8'h00, b, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {8'h00, res_beats, res_data}, 32'hDEAD_BEEF);
      end else begin
        chk("result", {8'h00, res_beats, res_data}, sb_q.pop_front());
      end
    end
  end

  initial begin
    int t0, t1, n;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_red_e", {16'd0, red_e}, 32'h0000FFFF);
    chk("rst_red_ops", {31'd0, (red_ops != '0)}, 32'd0);
    chk("rst_red_func", {31'd0, red_func}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_res_beats", {24'd0, res_beats}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-beat min-plus, latency of one cycle
    expect_res(16'd3, 8'd1);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 4'hF, 1'b1, 1'b0);
    chk("single_ops", {31'd0, (red_ops === pk(1, 2, 3, 4, 5, 6, 7, 8))}, 32'd1);
    chk("single_valid_early", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("single_valid", {31'd0, res_valid}, 32'd1);
    chk("single_data", {16'd0, res_data}, 32'd3);
    idle(2);

    // Two-beat min-plus, accumulator fed back
    expect_res(16'd5, 8'd2);
    send(pk(5, 5, 10, 10, 15, 15, 20, 20), 4'hF, 1'b0, 1'b0);
    send(pk(20, 5, 2, 3, 30, 30, 4, 5), 4'hF, 1'b1, 1'b0);
    chk("two_beat_red_e", {16'd0, red_e}, 32'd10);
    idle(3);

    // Min-times, func flip on the second beat ignored
    expect_res(16'd6, 8'd2);
    send(pk(3, 4, 2, 3, 10, 10, 2, 4), 4'hF, 1'b0, 1'b1);
    send(pk(7, 1, 5, 10, 3, 3, 4, 5), 4'hF, 1'b1, 1'b0);
    chk("mintimes_func_held", {31'd0, red_func}, 32'd1);
    idle(3);

    // Keep masking, including illegal keep[0]=0 and a partial mask
    expect_res(16'd8, 8'd1);
    send(pk(4, 4, 0, 1, 0, 0, 2, 2), 4'b0001, 1'b1, 1'b0);
    expect_res(16'd8, 8'd1);
    send(pk(4, 4, 0, 1, 0, 0, 2, 2), 4'b0000, 1'b1, 1'b0);
    expect_res(16'd4, 8'd1);
    send(pk(4, 4, 0, 1, 0, 0, 2, 2), 4'b1001, 1'b1, 1'b0);
    idle(3);

    // Unsigned wrap of the sum inside the reduction unit
    expect_res(16'd1, 8'd1);
    send(pk(16'hFFFF, 2, 5, 5, 6, 6, 7, 7), 4'hF, 1'b1, 1'b0);
    idle(3);

    // Backpressure: two single-beat vectors against a blocked slot
    res_ready = 1'b0;
    expect_res(16'd3, 8'd1);
    send(pk(1, 2, 3, 4, 5, 6, 7, 8), 4'hF, 1'b1, 1'b0);
    expect_res(16'd9, 8'd1);
    send(pk(4, 5, 5, 5, 6, 6, 7, 7), 4'hF, 1'b1, 1'b0);
    repeat (3) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_res_data", {16'd0, res_data}, 32'd3);
      chk("bp_ops_held", {31'd0, (red_ops === pk(4, 5, 5, 5, 6, 6, 7, 7))}, 32'd1);
      idle(1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_refill_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_refill_data", {16'd0, res_data}, 32'd9);
    @(posedge clk); #1;
    chk("bp_drained", {31'd0, res_valid}, 32'd0);
    idle(2);

    // Long vector: counter saturation and one-beat-per-cycle throughput
    expect_res(16'd50, 8'd255);
    t0 = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) send(pk(20, 30, 50, 50, 50, 50, 50, 50), 4'hF, 1'b0, 1'b0);
      else          send(pk(50, 50, 50, 50, 50, 50, 50, 50), 4'hF, (i == 299), 1'b0);
      if (i == 0) t0 = cyc;
    end
    t1 = cyc;
    chk("throughput", t1 - t0, 32'd299);
    idle(3);

    // Reset in the middle of a 3-beat vector
    send(pk(1, 1, 9, 9, 9, 9, 9, 9), 4'hF, 1'b0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_red_e", {16'd0, red_e}, 32'h0000FFFF);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    expect_res(16'd7, 8'd1);
    send(pk(3, 4, 5, 5, 6, 6, 7, 7), 4'hF, 1'b1, 1'b0);
    chk("midrst_fresh_red_e", {16'd0, red_e}, 32'h0000FFFF);
    @(posedge clk); #1;
    chk("midrst_fresh_data", {16'd0, res_data}, 32'd7);
    chk("midrst_fresh_beats", {24'd0, res_beats}, 32'd1);

    // Drain: every expected result must have been consumed
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    idle(2);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_semiring_dot_sequencer
`default_nettype wire
